// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, parity encodings and transmit state type
package uart_pkg;

  // Ticks per line bit; the tick strobe runs at 16x the baud rate.
  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead read data and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  // A write while full is dropped even if a read frees a slot on the same edge.
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr];

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/transmitter.sv
// rtl/transmitter.sv - buffered UART transmitter, LSB first, optional parity, 1 or 2 stop bits
module transmitter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("transmitter: STOP_BITS must be 1 or 2");
  end
  if ((PARITY != PAR_NONE) && (PARITY != PAR_EVEN) && (PARITY != PAR_ODD)) begin : g_bad_parity
    $error("transmitter: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end

  tx_state_e             state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  out_q, out_d;
  logic                  done_q, done_d;
  logic                  adv;
  logic                  load;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (fifo_rdata),
    .full  (tx_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A line bit ends on the tick that wraps the oversample counter.
  assign adv = tick && (cnt_q == TW'(OVERSAMPLE - 1));

  // Next-state, bit sequencing and line level; loading a word never waits for a tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    load    = 1'b0;
    out_d   = 1'b1;

    if ((state_q != IDLE) && tick) begin
      cnt_d = cnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        load  = !fifo_empty;
      end
      START: begin
        if (adv) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (adv) begin
          shift_d = shift_q >> 1;
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (adv) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (adv) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
            load    = !fifo_empty;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = START;
      shift_d = fifo_rdata;
      par_d   = (^fifo_rdata) ^ (PARITY == PAR_ODD);
      cnt_d   = '0;
    end

    case (state_d)
      START:            out_d = 1'b0;
      DATA:             out_d = shift_d[0];
      uart_pkg::PARITY: out_d = par_d;
      default:          out_d = 1'b1;
    endcase
  end

  assign pop = load;

  // State register; reset aborts any frame and returns the line to idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign tx_out  = out_q;
  assign tx_done = done_q;
  assign tx_busy = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - randomized scoreboard bench for transmitter across parity/stop-bit configurations
module tb_transmitter;

  localparam int NI    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic start_wr = 1'b0;
  logic stop_wr = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int PAR = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
    localparam int SB  = (g == 2) ? 2 : 1;
    localparam int NB  = 1 + DW + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FT  = 16 * NB;

    logic          tx_wr;
    logic [DW-1:0] tx_data;
    logic          tx_full, tx_out, tx_busy, tx_done;
    logic          idle;

    transmitter #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .PARITY     (PAR),
      .STOP_BITS  (SB)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .tx_data (tx_data),
      .tx_wr   (tx_wr),
      .tx_full (tx_full),
      .tx_out  (tx_out),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
    );

    // Stimulus: a directed burst that overfills the FIFO, then random writes at varying rates.
    initial begin
      logic [7:0] dir [9];
      int rate;
      int cyc;
      dir = '{8'h55, 8'hF0, 8'h3C, 8'h07, 8'hA5, 8'h0F, 8'h12, 8'h34, 8'h99};
      rate = 5;
      cyc = 0;
      tx_wr = 1'b0;
      tx_data = '0;
      wait (start_wr);
      @(posedge clk); #1;
      for (int i = 0; i < 9; i++) begin
        tx_wr = 1'b1;
        tx_data = dir[i];
        @(posedge clk); #1;
      end
      tx_wr = 1'b0;
      while (!stop_wr) begin
        if (cyc % 1500 == 0) begin
          case ($urandom_range(0, 2))
            0:       rate = 2;
            1:       rate = 8;
            default: rate = 60;
          endcase
        end
        cyc++;
        tx_wr = ($urandom_range(0, 999) < rate);
        tx_data = DW'($urandom);
        @(posedge clk); #1;
      end
      tx_wr = 1'b0;
    end

    // Monitor: line-level reference with a word queue, expected bit list per frame and tick counting.
    initial begin
      logic [DW-1:0] q[$];
      logic          bits [NB];
      logic [DW-1:0] w;
      logic [DW-1:0] push_data;
      logic          in_frame, push_flag, rst_next, tick_next, got, exp_done, exp_line;
      int            tcnt;
      in_frame = 1'b0;
      push_flag = 1'b0;
      push_data = '0;
      rst_next = 1'b1;
      tick_next = 1'b0;
      tcnt = 0;
      idle = 1'b1;
      for (int b = 0; b < NB; b++) bits[b] = 1'b1;
      forever begin
        @(negedge clk);
        if (rst_next) begin
          q.delete();
          in_frame = 1'b0;
          tcnt = 0;
          chk("reset tx_out", g, tx_out, 1);
          chk("reset tx_busy", g, tx_busy, 0);
          chk("reset tx_full", g, tx_full, 0);
          chk("reset tx_done", g, tx_done, 0);
        end else begin
          got = tick_next;
          exp_done = 1'b0;
          if (in_frame && got) tcnt++;
          if (in_frame && (tcnt == FT)) begin
            in_frame = 1'b0;
            exp_done = 1'b1;
          end
          if (!in_frame && (q.size() > 0)) begin
            w = q.pop_front();
            bits[0] = 1'b0;
            for (int b = 0; b < DW; b++) bits[1 + b] = w[b];
            if (PAR != 0) bits[1 + DW] = (^w) ^ (PAR == 2);
            for (int s = 0; s < SB; s++) bits[NB - 1 - s] = 1'b1;
            tcnt = 0;
            in_frame = 1'b1;
          end
          if (push_flag) q.push_back(push_data);
          exp_line = in_frame ? bits[tcnt / 16] : 1'b1;
          chk("tx_out line", g, tx_out, exp_line);
          chk("tx_done", g, tx_done, exp_done);
          chk("tx_busy", g, tx_busy, in_frame || (q.size() > 0));
        end
        chk("tx_full", g, tx_full, q.size() == DEPTH);
        rst_next = rst;
        tick_next = tick;
        push_flag = !rst && tx_wr && (q.size() < DEPTH);
        push_data = tx_data;
        idle = !in_frame && (q.size() == 0);
      end
    end
  end

  // Tick strobe with random spacing, changed away from the sampling edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      tick = ($urandom_range(0, 2) == 0);
    end
  end

  // Sequence: reset, traffic, two mid-stream resets, drain, summary.
  initial begin
    int waited;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    start_wr = 1'b1;
    repeat (14000) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (14000) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10000) @(posedge clk);
    stop_wr = 1'b1;
    repeat (4) @(posedge clk);
    waited = 0;
    while (!(g_inst[0].idle && g_inst[1].idle && g_inst[2].idle) && (waited < 20000)) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    chk("drain idle", 0, g_inst[0].idle, 1);
    chk("drain idle", 1, g_inst[1].idle, 1);
    chk("drain idle", 2, g_inst[2].idle, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
